// File: rtl/skew_mes_pkg.sv
// Shared types for the multi-channel skew measurement controller.
//   err_type_t : global error code reported on err_o
//   ch_stat_t  : per-channel measurement status reported on ch_stat_o
//   state_t    : controller FSM state
//   phase_t    : master alignment sweep vs. slave measurement sweep
package skew_mes_pkg;

   typedef enum logic [2:0] {
      NO_ERR               = 3'd0,
      CAN_NOT_ALIGN_MASTER = 3'd1,
      STB_TIMEOUT          = 3'd2
   } err_type_t;

   typedef enum logic [1:0] {
      NOT_RUN   = 2'd0,
      OK        = 2'd1,
      SATURATED = 2'd2
   } ch_stat_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_REQ_STB,
      S_WAIT_STB,
      S_EVAL,
      S_INC_DELAY,
      S_NEXT_CH,
      S_ERR,
      S_READY
   } state_t;

   typedef enum logic {
      PH_MASTER,
      PH_SLAVE
   } phase_t;

   // Width of the channel select; a single channel still needs one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/skew_mes_ctl_mc_if.sv
// Front-end bundle between the controller and the shared delay line /
// comparator block.
//   delay_code_o : delay line code (controller -> front end)
//   stb_req_o    : one-cycle strobe request (controller -> front end)
//   stb_valid_i  : one-cycle strobe result valid (front end -> controller)
//   m_cmp_out_i  : master comparator output
//   s_cmp_out_i  : slave comparator outputs, one per channel
// Modports: master = controller side, slave = front-end side.
interface skew_mes_ctl_mc_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = 10
);

   logic [DW-1:0]  delay_code_o;
   logic           stb_req_o;
   logic           stb_valid_i;
   logic           m_cmp_out_i;
   logic [NCH-1:0] s_cmp_out_i;

   modport master (
      output delay_code_o, stb_req_o,
      input  stb_valid_i, m_cmp_out_i, s_cmp_out_i
   );

   modport slave (
      input  delay_code_o, stb_req_o,
      output stb_valid_i, m_cmp_out_i, s_cmp_out_i
   );

endinterface

// File: rtl/skew_sample_acc.sv
// Majority-vote accumulator for one delay point.
//   clk_i, arst_i : clock, async active-high reset
//   clr_i         : zero hit and sample counters (wins over add_i)
//   add_i         : accumulate one comparator sample
//   cmp_i         : comparator value of the sample being accumulated
//   maj_o         : strict majority of accumulated samples were high
//   done_o        : the sample being accumulated completes the point
module skew_sample_acc #(
   parameter int unsigned NSAMP = 4
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic clr_i,
   input  logic add_i,
   input  logic cmp_i,
   output logic maj_o,
   output logic done_o
);

   localparam int unsigned CW = $clog2(NSAMP + 1);

   logic [CW-1:0] hits_q;
   logic [CW-1:0] smp_q;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         hits_q <= '0;
         smp_q  <= '0;
      end else if (clr_i) begin
         hits_q <= '0;
         smp_q  <= '0;
      end else if (add_i) begin
         hits_q <= hits_q + CW'(cmp_i);
         smp_q  <= smp_q + CW'(1);
      end
   end

   // Evaluated combinationally so the FSM can leave WAIT_STB on the last strobe.
   assign done_o = add_i && (smp_q == CW'(NSAMP - 1));
   assign maj_o  = (hits_q > CW'(NSAMP / 2));

endmodule

// File: rtl/skew_mes_ctl_mc.sv
// Multi-channel skew measurement controller.
// Sweeps the delay code until the master comparator flips (majority of
// NSAMP strobes), then re-sweeps from that code for every enabled slave
// channel and records the code distance as that channel's skew.
//   clk_i, arst_i : clock, async active-high reset
//   run_i         : 1 = measure, 0 = abort to IDLE
//   chan_en_i     : slave enable mask, latched at start
//   fe            : delay line / comparator front end (master modport)
//   ch_sel_o      : slave channel currently measured
//   res_o         : per-channel skew, channel k at [k*DW +: DW]
//   ch_stat_o     : per-channel ch_stat_t, channel k at [k*2 +: 2]
//   err_o         : global error, NO_ERR outside ERR
//   busy_o, rdy_o : activity / completion flags
module skew_mes_ctl_mc
   import skew_mes_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DW    = 10,
   parameter int unsigned NSAMP = 4,
   parameter int unsigned TMO   = 1023
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         run_i,
   input  logic [NCH-1:0]               chan_en_i,
   skew_mes_ctl_mc_if.master            fe,
   output logic [sel_width(NCH)-1:0]    ch_sel_o,
   output logic [NCH*DW-1:0]            res_o,
   output logic [NCH*2-1:0]             ch_stat_o,
   output err_type_t                    err_o,
   output logic                         busy_o,
   output logic                         rdy_o
);

   localparam int unsigned CSW = sel_width(NCH);
   localparam int unsigned TW  = $clog2(TMO + 1);

   state_t         state_q, state_d;
   phase_t         phase_q;
   logic [NCH-1:0] en_q;
   logic [DW-1:0]  code_q;
   logic [DW-1:0]  m_code_q;
   logic [CSW-1:0] sel_q;
   logic [DW-1:0]  res_q [NCH];
   ch_stat_t       stat_q [NCH];
   err_type_t      err_q;
   logic [TW-1:0]  tmo_q;
   logic           stb_req_q;

   logic           acc_clr, acc_add, acc_maj, acc_done, cmp;
   logic           first_vld, next_vld;
   logic [CSW-1:0] first_idx, next_idx;

   assign cmp = (phase_q == PH_MASTER) ? fe.m_cmp_out_i : fe.s_cmp_out_i[sel_q];

   skew_sample_acc #(.NSAMP(NSAMP)) u_acc (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .clr_i  (acc_clr),
      .add_i  (acc_add),
      .cmp_i  (cmp),
      .maj_o  (acc_maj),
      .done_o (acc_done)
   );

   // Lowest enabled channel overall, and lowest enabled channel above sel_q.
   // Scanning downwards lets the last hit (the lowest index) win.
   always_comb begin
      first_vld = 1'b0;
      next_vld  = 1'b0;
      first_idx = '0;
      next_idx  = '0;
      for (int unsigned k = NCH; k > 0; k--) begin
         if (en_q[k-1]) begin
            first_vld = 1'b1;
            first_idx = CSW'(k - 1);
            if ((k - 1) > int'(sel_q)) begin
               next_vld = 1'b1;
               next_idx = CSW'(k - 1);
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; dropping run_i overrides every transition.
   always_comb begin
      state_d = state_q;
      if (!run_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:      state_d = S_LOAD;
            S_LOAD:      state_d = S_REQ_STB;
            S_REQ_STB:   state_d = S_WAIT_STB;
            S_WAIT_STB: begin
               if (fe.stb_valid_i)             state_d = acc_done ? S_EVAL : S_REQ_STB;
               else if (tmo_q == TW'(TMO))     state_d = S_ERR;
            end
            S_EVAL: begin
               if (!acc_maj)                   state_d = S_INC_DELAY;
               else if (phase_q == PH_SLAVE)   state_d = S_NEXT_CH;
               else if (code_q == '0)          state_d = S_ERR;
               else                            state_d = first_vld ? S_LOAD : S_READY;
            end
            S_INC_DELAY: begin
               if (code_q != '1)               state_d = S_REQ_STB;
               else                            state_d = (phase_q == PH_MASTER) ? S_ERR : S_NEXT_CH;
            end
            S_NEXT_CH:   state_d = next_vld ? S_LOAD : S_READY;
            S_ERR:       state_d = S_ERR;
            S_READY:     state_d = S_READY;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Output / control decode
   always_comb begin
      busy_o  = 1'b1;
      rdy_o   = 1'b0;
      err_o   = NO_ERR;
      acc_add = 1'b0;
      acc_clr = !run_i;
      case (state_q)
         S_IDLE:              begin busy_o = 1'b0; acc_clr = 1'b1; end
         S_LOAD, S_INC_DELAY: acc_clr = 1'b1;
         S_WAIT_STB:          acc_add = fe.stb_valid_i;
         S_ERR:               begin busy_o = 1'b0; err_o = err_q; end
         S_READY:             begin busy_o = 1'b0; rdy_o = 1'b1; end
         default:             ;
      endcase
   end

   // Datapath; nothing is committed in a cycle where run_i is low, so an
   // abort coinciding with the deciding strobe leaves results untouched.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         phase_q  <= PH_MASTER;
         en_q     <= '0;
         code_q   <= '0;
         m_code_q <= '0;
         sel_q    <= '0;
         err_q    <= NO_ERR;
         for (int unsigned k = 0; k < NCH; k++) begin
            res_q[k]  <= '0;
            stat_q[k] <= NOT_RUN;
         end
      end else if (!run_i) begin
         phase_q <= PH_MASTER;
         code_q  <= '0;
         err_q   <= NO_ERR;
      end else begin
         case (state_q)
            S_IDLE: begin
               en_q    <= chan_en_i;
               sel_q   <= '0;
               phase_q <= PH_MASTER;
               code_q  <= '0;
               err_q   <= NO_ERR;
               for (int unsigned k = 0; k < NCH; k++) begin
                  res_q[k]  <= '0;
                  stat_q[k] <= NOT_RUN;
               end
            end
            S_LOAD: begin
               if (phase_q == PH_SLAVE) code_q <= m_code_q;
            end
            S_WAIT_STB: begin
               if (!fe.stb_valid_i && tmo_q == TW'(TMO)) err_q <= STB_TIMEOUT;
            end
            S_EVAL: begin
               if (acc_maj) begin
                  if (phase_q == PH_SLAVE) begin
                     res_q[sel_q]  <= code_q - m_code_q;
                     stat_q[sel_q] <= OK;
                  end else if (code_q == '0) begin
                     err_q <= CAN_NOT_ALIGN_MASTER;
                  end else begin
                     m_code_q <= code_q;
                     phase_q  <= PH_SLAVE;
                     if (first_vld) sel_q <= first_idx;
                  end
               end
            end
            S_INC_DELAY: begin
               if (code_q != '1) begin
                  code_q <= code_q + DW'(1);
               end else if (phase_q == PH_MASTER) begin
                  err_q <= CAN_NOT_ALIGN_MASTER;
               end else begin
                  res_q[sel_q]  <= '1;
                  stat_q[sel_q] <= SATURATED;
               end
            end
            S_NEXT_CH: begin
               if (next_vld) sel_q <= next_idx;
            end
            default: ;
         endcase
      end
   end

   // Strobe timeout counter and registered strobe request
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         tmo_q     <= '0;
         stb_req_q <= 1'b0;
      end else begin
         stb_req_q <= run_i && (state_q == S_REQ_STB);
         if (state_q == S_REQ_STB)
            tmo_q <= '0;
         else if (state_q == S_WAIT_STB && tmo_q != TW'(TMO))
            tmo_q <= tmo_q + TW'(1);
      end
   end

   assign fe.delay_code_o = code_q;
   assign fe.stb_req_o    = stb_req_q;
   assign ch_sel_o        = sel_q;

   for (genvar k = 0; k < NCH; k++) begin : g_pack
      assign res_o[k*DW +: DW]   = res_q[k];
      assign ch_stat_o[k*2 +: 2] = stat_q[k];
   end

endmodule

// File: tb/tb_skew_mes_ctl_mc.sv
// Self-checking bench for skew_mes_ctl_mc: table of measurement runs plus
// hand-written timeout and abort sequences. A behavioural front end answers
// each strobe request with comparator values derived from per-channel
// threshold codes.
module tb_skew_mes_ctl_mc;
   import skew_mes_pkg::*;

   localparam int unsigned NCH   = 4;
   localparam int unsigned DW    = 10;
   localparam int unsigned NSAMP = 4;
   localparam int unsigned TMO   = 1023;
   localparam logic [10:0] NEVER = 11'd2000;

   logic clk = 1'b0;
   logic arst, run;
   logic [NCH-1:0]    chan_en;
   logic [1:0]        ch_sel;
   logic [NCH*DW-1:0] res;
   logic [NCH*2-1:0]  stat;
   err_type_t         err;
   logic              busy, rdy;

   skew_mes_ctl_mc_if #(.NCH(NCH), .DW(DW)) fe ();

   skew_mes_ctl_mc #(.NCH(NCH), .DW(DW), .NSAMP(NSAMP), .TMO(TMO)) dut (
      .clk_i     (clk),
      .arst_i    (arst),
      .run_i     (run),
      .chan_en_i (chan_en),
      .fe        (fe),
      .ch_sel_o  (ch_sel),
      .res_o     (res),
      .ch_stat_o (stat),
      .err_o     (err),
      .busy_o    (busy),
      .rdy_o     (rdy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       mask;
      logic [10:0]      m_thr;
      logic [3:0][10:0] s_thr;
      logic [3:0]       part;
      logic [2:0]       e_err;
      logic             e_rdy;
      logic [3:0][9:0]  e_res;
      logic [3:0][1:0]  e_stat;
   } vec_t;

   vec_t vecs [7];

   int n_vec  = 0;
   int n_miss = 0;

   // Front-end model state
   logic             resp_en;
   logic [10:0]      mdl_m_thr;
   logic [3:0][10:0] mdl_s_thr;
   logic [3:0]       mdl_part;
   int               samp_k;
   int               sel_bad;
   int               r_idx, r_code;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Partial channels give 2 of 4 hits one code before threshold and
   // 3 of 4 at threshold; otherwise a clean step at threshold.
   function automatic logic cmp_model(input int thr, input logic part, input int code, input int idx);
      if (part && code == thr - 1) return (idx < 2);
      if (part && code == thr)     return (idx != 3);
      return (code >= thr);
   endfunction

   function automatic vec_t mk(input logic [3:0] mask, input logic [10:0] m,
                               input logic [3:0][10:0] s, input logic [3:0] part,
                               input logic [2:0] e_err, input logic e_rdy,
                               input logic [3:0][9:0] e_res, input logic [3:0][1:0] e_stat);
      vec_t r;
      r.mask = mask; r.m_thr = m; r.s_thr = s; r.part = part;
      r.e_err = e_err; r.e_rdy = e_rdy; r.e_res = e_res; r.e_stat = e_stat;
      return r;
   endfunction

   // Responder: answers a request in the same half-cycle it is seen.
   initial begin
      fe.stb_valid_i = 1'b0;
      fe.m_cmp_out_i = 1'b0;
      fe.s_cmp_out_i = '0;
      samp_k = 0;
      forever begin
         @(negedge clk);
         if (!resp_en) samp_k = 0;
         if (fe.stb_valid_i) begin
            fe.stb_valid_i = 1'b0;
         end else if (resp_en && fe.stb_req_o) begin
            r_idx  = samp_k % NSAMP;
            r_code = int'(fe.delay_code_o);
            fe.m_cmp_out_i = cmp_model(int'(mdl_m_thr), 1'b0, r_code, r_idx);
            for (int ch = 0; ch < NCH; ch++)
               fe.s_cmp_out_i[ch] = cmp_model(int'(mdl_s_thr[ch]), mdl_part[ch], r_code, r_idx);
            fe.stb_valid_i = 1'b1;
            samp_k++;
         end
      end
   end

   // Channel select must stay inside the latched mask while busy.
   initial begin
      sel_bad = 0;
      forever begin
         @(negedge clk);
         if (busy && chan_en != '0 && !chan_en[ch_sel]) sel_bad++;
      end
   end

   task automatic wait_end(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         if (rdy || err != NO_ERR) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_req(input int n, output logic ok);
      int seen = 0;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (fe.stb_req_o) seen++;
         if (seen == n) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic start(input logic [3:0] mask, input logic [10:0] m,
                        input logic [3:0][10:0] s, input logic [3:0] part, input logic resp);
      resp_en = 1'b0;
      @(negedge clk);
      mdl_m_thr = m; mdl_s_thr = s; mdl_part = part; chan_en = mask;
      resp_en = resp;
      run = 1'b1;
   endtask

   initial begin
      logic ok;
      int   bad0;
      arst = 1'b1; run = 1'b0; chan_en = '0; resp_en = 1'b0;
      mdl_m_thr = '0; mdl_s_thr = '0; mdl_part = '0;
      repeat (3) @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      chk("rst code",    fe.delay_code_o, 0);
      chk("rst ch_sel",  ch_sel, 0);
      chk("rst res",     res, 0);
      chk("rst stat",    stat, 0);
      chk("rst err",     err, NO_ERR);
      chk("rst busy",    busy, 0);
      chk("rst rdy",     rdy, 0);
      chk("rst stb_req", fe.stb_req_o, 0);

      vecs[0] = mk(4'hF, 11'd100, {11'd1023, 11'd250, 11'd100, 11'd103}, 4'h0,
                   3'd0, 1'b1, {10'd923, 10'd150, 10'd0, 10'd3}, {2'd1, 2'd1, 2'd1, 2'd1});
      vecs[1] = mk(4'hF, 11'd0, {11'd200, 11'd200, 11'd200, 11'd200}, 4'h0,
                   3'd1, 1'b0, {10'd0, 10'd0, 10'd0, 10'd0}, {2'd0, 2'd0, 2'd0, 2'd0});
      vecs[2] = mk(4'hF, 11'd100, {11'd250, NEVER, 11'd100, 11'd103}, 4'h0,
                   3'd0, 1'b1, {10'd150, 10'h3FF, 10'd0, 10'd3}, {2'd1, 2'd2, 2'd1, 2'd1});
      vecs[3] = mk(4'b0101, 11'd100, {11'd140, 11'd130, 11'd105, 11'd110}, 4'h0,
                   3'd0, 1'b1, {10'd0, 10'd30, 10'd0, 10'd10}, {2'd0, 2'd1, 2'd0, 2'd1});
      vecs[4] = mk(4'b0001, 11'd100, {11'd200, 11'd200, 11'd200, 11'd121}, 4'b0001,
                   3'd0, 1'b1, {10'd0, 10'd0, 10'd0, 10'd21}, {2'd0, 2'd0, 2'd0, 2'd1});
      vecs[5] = mk(4'b0000, 11'd50, {11'd60, 11'd60, 11'd60, 11'd60}, 4'h0,
                   3'd0, 1'b1, {10'd0, 10'd0, 10'd0, 10'd0}, {2'd0, 2'd0, 2'd0, 2'd0});
      vecs[6] = mk(4'hF, NEVER, {11'd60, 11'd60, 11'd60, 11'd60}, 4'h0,
                   3'd1, 1'b0, {10'd0, 10'd0, 10'd0, 10'd0}, {2'd0, 2'd0, 2'd0, 2'd0});

      for (int v = 0; v < 7; v++) begin
         bad0 = sel_bad;
         start(vecs[v].mask, vecs[v].m_thr, vecs[v].s_thr, vecs[v].part, 1'b1);
         wait_end(ok);
         chk($sformatf("v%0d finished", v), ok, 1);
         chk($sformatf("v%0d err", v),  err,  vecs[v].e_err);
         chk($sformatf("v%0d rdy", v),  rdy,  vecs[v].e_rdy);
         chk($sformatf("v%0d busy", v), busy, 0);
         for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("v%0d res%0d", v, ch),  res[ch*DW +: DW], vecs[v].e_res[ch]);
            chk($sformatf("v%0d stat%0d", v, ch), stat[ch*2 +: 2],  vecs[v].e_stat[ch]);
         end
         chk($sformatf("v%0d sel in mask", v), sel_bad - bad0, 0);
         run = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d idle busy", v), busy, 0);
         chk($sformatf("v%0d idle err", v),  err, NO_ERR);
         chk($sformatf("v%0d idle code", v), fe.delay_code_o, 0);
         for (int ch = 0; ch < NCH; ch++)
            chk($sformatf("v%0d hold res%0d", v, ch), res[ch*DW +: DW], vecs[v].e_res[ch]);
      end

      // Strobe never answered: timeout error.
      start(4'hF, 11'd100, {4{11'd200}}, 4'h0, 1'b0);
      repeat (500) @(negedge clk);
      chk("tmo early busy", busy, 1);
      chk("tmo early err",  err, NO_ERR);
      wait_end(ok);
      chk("tmo finished", ok, 1);
      chk("tmo err",  err, STB_TIMEOUT);
      chk("tmo rdy",  rdy, 0);
      chk("tmo busy", busy, 0);
      run = 1'b0;
      @(negedge clk);
      chk("tmo idle err", err, NO_ERR);

      // Abort mid-sweep right after a strobe is answered (state REQ_STB).
      start(4'hF, 11'd100, {4{11'd200}}, 4'h0, 1'b1);
      wait_req(50, ok);
      chk("abort req seen", ok, 1);
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("abort stb_req", fe.stb_req_o, 0);
      chk("abort busy",    busy, 0);
      chk("abort code",    fe.delay_code_o, 0);

      // Abort coincident with the strobe that completes the slave edge.
      start(4'b0001, 11'd3, {11'd60, 11'd60, 11'd60, 11'd5}, 4'h0, 1'b1);
      wait_req(28, ok);
      chk("race req seen", ok, 1);
      run = 1'b0;
      @(negedge clk);
      chk("race busy",  busy, 0);
      chk("race stat0", stat[1:0], NOT_RUN);
      chk("race res0",  res[DW-1:0], 0);
      chk("race code",  fe.delay_code_o, 0);

      resp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/skew_mes_ctl_mc.md
Name: skew_mes_ctl_mc

Overview:
- Multi-channel successor of the single-slave skew measurement controller. Sits between the CSR block and the shared programmable delay line / comparator front-end.
- Aligns the master comparator edge by sweeping the delay code, then measures the skew of each enabled slave channel in turn, relative to the master-aligned code.
- Adds majority-vote sampling per delay point, a strobe timeout, a channel enable mask and per-channel status.

Parameters:
- NCH, 4, number of slave comparator channels (1..16).
- DW, 10, delay code / result width.
- NSAMP, 4, strobes taken per delay point (1..15).
- TMO, 1023, max cycles waiting for stb_valid_i before timeout error.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  async reset, active high
- run_i  in  1  level; 1 = run measurement, 0 = abort and return to IDLE
- chan_en_i  in  NCH  slave channel enable mask, sampled in IDLE→LOAD
- m_cmp_out_i  in  1  master comparator output
- s_cmp_out_i  in  NCH  slave comparator outputs
- delay_code_o  out  DW  delay line code
- ch_sel_o  out  $clog2(NCH) (min 1)  slave channel currently measured
- res_o  out  NCH*DW  per-channel skew, channel k at [k*DW +: DW]
- ch_stat_o  out  NCH*2  per-channel status (ch_stat_t)
- err_o  out  3  global error (err_type_t)
- busy_o  out  1  high in every state except IDLE, READY, ERR
- rdy_o  out  1  high in READY
- stb_req_o  out  1  one-cycle strobe request
- stb_valid_i  in  1  strobe result valid (one-cycle pulse)

Behaviour:
- Reset: state IDLE, phase MASTER, delay_code_o=0, ch_sel_o=0, res_o=0, ch_stat_o all NOT_RUN, err_o=NO_ERR, stb_req_o=0, rdy_o=0, busy_o=0.
- run_i=0 in any state: go to IDLE next cycle. Clears delay_code_o, the hit counter and phase. res_o and ch_stat_o hold.
- FSM states: IDLE, LOAD, REQ_STB, WAIT_STB, EVAL, INC_DELAY, NEXT_CH, ERR, READY.
- IDLE (run_i=1) → LOAD:
  - Latch chan_en_i.
  - Clear res_o and set ch_stat_o to NOT_RUN.
  - Zero the hit and sample counters.
- LOAD → REQ_STB.
- REQ_STB → WAIT_STB. stb_req_o is registered high in the cycle after REQ_STB, for exactly one cycle.
- WAIT_STB:
  - On stb_valid_i: sample cmp, where cmp = m_cmp_out_i in MASTER phase, else s_cmp_out_i[ch_sel_o]. Add cmp to hits and increment samples.
  - If samples==NSAMP → EVAL, else → REQ_STB.
  - Timeout counter: cleared on REQ_STB. If it reaches TMO without stb_valid_i → ERR with STB_TIMEOUT.
- EVAL: edge = (hits > NSAMP/2), i.e. strict majority.
  - MASTER, edge, code==0 → ERR, CAN_NOT_ALIGN_MASTER.
  - MASTER, edge, code>0 → latch m_code=code, set phase SLAVE, ch_sel_o = first enabled channel → LOAD.
    - No channel enabled → READY.
    - LOAD in SLAVE phase reloads delay_code_o=m_code.
  - SLAVE, edge → res[ch] = code − m_code (mod 2^DW), ch_stat OK → NEXT_CH.
  - No edge → INC_DELAY.
- INC_DELAY:
  - code==2^DW−1, MASTER → ERR, CAN_NOT_ALIGN_MASTER.
  - code==2^DW−1, SLAVE → ch_stat SATURATED, res[ch]=all-ones → NEXT_CH.
    - A SATURATED slave is not a global error; remaining channels still run.
  - Otherwise code+1, clear hits and samples → REQ_STB.
- NEXT_CH: advance ch_sel_o to the next enabled channel → LOAD. If none remain → READY.
- Slave edge at code==m_code: res=0, status OK.
- ERR and READY hold until run_i=0. err_o is NO_ERR outside ERR.
- Edge found at NSAMP-th sample and stb_valid_i coincident with run_i falling: abort wins, result not written.

Decomposition:
- skew_mes_pkg:
  - err_type_t: NO_ERR, CAN_NOT_ALIGN_MASTER, STB_TIMEOUT.
  - ch_stat_t: NOT_RUN, OK, SATURATED.
  - FSM state enum and phase enum.
- Sub-module skew_sample_acc: hit/sample counters, majority decision, clear/accumulate controls, done flag.

Test Plan:
- NCH=4, mask 4'b1111, master edge at code 100, slave edges at 103/100/250/1023 → res 3/0/150/923, all OK, rdy_o=1.
- Master comparator high at code 0 → err_o=CAN_NOT_ALIGN_MASTER, rdy_o=0; run_i=0 → IDLE, delay_code_o=0.
- Slave 2 never rises → ch_stat[2]=SATURATED, res[2]=0x3FF; other channels OK; READY reached.
- Mask 4'b0101 → only channels 0,2 measured (ch_sel_o never 1 or 3); channels 1,3 NOT_RUN.
- NSAMP=4, slave gives 2 of 4 hits at code 120 and 3 of 4 at 121 → res uses code 121.
- stb_valid_i withheld TMO cycles → err_o=STB_TIMEOUT. Separately, run_i dropped mid-sweep → IDLE next cycle, stb_req_o=0.
